// File: rtl/vga_sync_generator_pkg.sv
// Shared 640x480@60 raster constants and colour definitions for the scan
// generator and every GUI component that decodes row/col.
package vga_sync_generator_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int COLOR_W = 3;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t BLACK   = 3'b000;
    localparam color_t BLUE    = 3'b001;
    localparam color_t GREEN   = 3'b010;
    localparam color_t CYAN    = 3'b011;
    localparam color_t RED     = 3'b100;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t WHITE   = 3'b111;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on en and decodes the visible and sync
// regions of the current position.
module vga_axis_counter
    import vga_sync_generator_pkg::*;
#(
    parameter int VISIBLE = VGA_H_VISIBLE,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK
) (
    input  logic             tick,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             visible,
    output logic             sync_active
);

    localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_START = VISIBLE + FRONT;
    localparam int SYNC_END   = VISIBLE + FRONT + SYNC;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    if (TOTAL > CNT_MAX) begin : g_total_too_large
        $error("vga_axis_counter: TOTAL %0d exceeds the 10-bit counter range", TOTAL);
    end

    // wrap flags the terminal count; the caller qualifies it with en.
    assign wrap        = (cnt == LAST);
    assign visible     = (int'(cnt) < VISIBLE);
    assign sync_active = (int'(cnt) >= SYNC_START) && (int'(cnt) < SYNC_END);

    always_ff @(posedge tick) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: pixel divider, h/v counters, blanked colour and
// registered syncs, plus a once-per-frame tick at the start of vertical blanking.
module vga_sync_generator
    import vga_sync_generator_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 2
) (
    input  logic               tick,
    input  logic               reset,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic [CNT_W-1:0]   row,
    output logic [CNT_W-1:0]   col,
    output logic               visible,
    output logic               pixel_en,
    output logic [COLOR_W-1:0] vga_rgb,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               frame_tick
);

    localparam logic [4:0]       DIV_LAST    = 5'(CLK_DIV - 1);
    localparam logic             SYNC_ACTIVE = (SYNC_POL != 0);
    localparam logic [CNT_W-1:0] V_LAST_VIS  = CNT_W'(V_VISIBLE - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_sync_generator: CLK_DIV %0d outside 1..16", CLK_DIV);
    end

    logic [4:0] div_cnt;
    logic       h_wrap, h_visible, h_sync;
    logic       v_wrap_unused, v_visible, v_sync;

    // Gating with reset keeps CLK_DIV=1 from strobing during the reset tick.
    assign pixel_en = !reset && (div_cnt == DIV_LAST);

    always_ff @(posedge tick) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h_axis (
        .tick(tick), .reset(reset), .en(pixel_en),
        .cnt(col), .wrap(h_wrap), .visible(h_visible), .sync_active(h_sync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v_axis (
        .tick(tick), .reset(reset), .en(pixel_en && h_wrap),
        .cnt(row), .wrap(v_wrap_unused), .visible(v_visible), .sync_active(v_sync)
    );

    assign visible = h_visible && v_visible;

    // Colour and syncs share one pixel of latency so they stay aligned at the DAC.
    always_ff @(posedge tick) begin
        if (reset) begin
            vga_rgb    <= BLACK;
            vga_hsync  <= ~SYNC_ACTIVE;
            vga_vsync  <= ~SYNC_ACTIVE;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pixel_en && h_wrap && (row == V_LAST_VIS);
            if (pixel_en) begin
                vga_rgb   <= visible ? rgb_in : BLACK;
                vga_hsync <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vga_vsync <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a standard 640x480 instance, a shrunken-raster
// instance for whole-frame checks, and a CLK_DIV=1 / active-high-sync instance.
module tb_vga_sync_generator;

    localparam int N = 3;
    localparam int P_HV[N]  = '{640, 8, 640};
    localparam int P_HF[N]  = '{16, 2, 16};
    localparam int P_HS[N]  = '{96, 3, 96};
    localparam int P_HB[N]  = '{48, 2, 48};
    localparam int P_VV[N]  = '{480, 6, 480};
    localparam int P_VF[N]  = '{10, 1, 10};
    localparam int P_VS[N]  = '{2, 2, 2};
    localparam int P_VB[N]  = '{33, 2, 33};
    localparam int P_POL[N] = '{0, 0, 1};
    localparam int P_DIV[N] = '{2, 3, 1};

    logic       tick = 1'b0;
    logic       reset;
    logic [2:0] rgb_in;

    logic [9:0] row_w[N];
    logic [9:0] col_w[N];
    logic [2:0] rgb_w[N];
    logic       vis_w[N], pen_w[N], hs_w[N], vs_w[N], ft_w[N];

    int checks = 0;
    int failures = 0;

    always #5 tick = ~tick;

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_sync_generator #(
            .H_VISIBLE(P_HV[g]), .H_FRONT(P_HF[g]), .H_SYNC(P_HS[g]), .H_BACK(P_HB[g]),
            .V_VISIBLE(P_VV[g]), .V_FRONT(P_VF[g]), .V_SYNC(P_VS[g]), .V_BACK(P_VB[g]),
            .SYNC_POL(P_POL[g]), .CLK_DIV(P_DIV[g])
        ) u_dut (
            .tick(tick), .reset(reset), .rgb_in(rgb_in),
            .row(row_w[g]), .col(col_w[g]), .visible(vis_w[g]), .pixel_en(pen_w[g]),
            .vga_rgb(rgb_w[g]), .vga_hsync(hs_w[g]), .vga_vsync(vs_w[g]),
            .frame_tick(ft_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference raster: counters advance at posedge; each pixel strobe pushes
    // the expected {id, rgb, hsync, vsync} that must appear after that edge.
    int         m_div[N], m_h[N], m_v[N];
    logic [2:0] m_rgb[N];
    logic       m_hs[N], m_vs[N], m_ft[N];
    bit         m_push[N];
    logic [6:0] exp_q[$];

    always @(posedge tick) begin
        bit   pen, vis, pol, hs, vs;
        int   ht, vt;
        for (int k = 0; k < N; k++) begin
            pol = (P_POL[k] != 0);
            ht  = P_HV[k] + P_HF[k] + P_HS[k] + P_HB[k];
            vt  = P_VV[k] + P_VF[k] + P_VS[k] + P_VB[k];
            m_push[k] = 1'b0;
            if (reset) begin
                m_div[k] = 0; m_h[k] = 0; m_v[k] = 0;
                m_rgb[k] = 3'b000; m_hs[k] = !pol; m_vs[k] = !pol; m_ft[k] = 1'b0;
            end else begin
                pen = (m_div[k] == P_DIV[k] - 1);
                m_ft[k] = pen && (m_h[k] == ht - 1) && (m_v[k] == P_VV[k] - 1);
                if (pen) begin
                    vis = (m_h[k] < P_HV[k]) && (m_v[k] < P_VV[k]);
                    hs = (m_h[k] >= P_HV[k] + P_HF[k] && m_h[k] < P_HV[k] + P_HF[k] + P_HS[k]) ? pol : !pol;
                    vs = (m_v[k] >= P_VV[k] + P_VF[k] && m_v[k] < P_VV[k] + P_VF[k] + P_VS[k]) ? pol : !pol;
                    exp_q.push_back({2'(k), vis ? rgb_in : 3'b000, hs, vs});
                    m_push[k] = 1'b1;
                    if (m_h[k] == ht - 1) begin
                        m_h[k] = 0;
                        m_v[k] = (m_v[k] == vt - 1) ? 0 : m_v[k] + 1;
                    end else begin
                        m_h[k] = m_h[k] + 1;
                    end
                end
                m_div[k] = pen ? 0 : m_div[k] + 1;
            end
        end
    end

    always @(negedge tick) begin
        logic [6:0] e;
        for (int k = 0; k < N; k++) begin
            if (m_push[k]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("u%0d.queue_empty", k), 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    m_rgb[k] = e[4:2]; m_hs[k] = e[1]; m_vs[k] = e[0];
                end
            end
            check($sformatf("u%0d.row", k), 32'(row_w[k]), 32'(m_v[k]));
            check($sformatf("u%0d.col", k), 32'(col_w[k]), 32'(m_h[k]));
            check($sformatf("u%0d.visible", k), 32'(vis_w[k]),
                  32'((m_h[k] < P_HV[k]) && (m_v[k] < P_VV[k])));
            check($sformatf("u%0d.pixel_en", k), 32'(pen_w[k]),
                  32'(!reset && (m_div[k] == P_DIV[k] - 1)));
            check($sformatf("u%0d.vga_rgb", k), 32'(rgb_w[k]), 32'(m_rgb[k]));
            check($sformatf("u%0d.vga_hsync", k), 32'(hs_w[k]), 32'(m_hs[k]));
            check($sformatf("u%0d.vga_vsync", k), 32'(vs_w[k]), 32'(m_vs[k]));
            check($sformatf("u%0d.frame_tick", k), 32'(ft_w[k]), 32'(m_ft[k]));
        end
    end

    // Standard instance: hsync low pixel count and the column where it first drops.
    int   s0_low_pens, s0_fall_col;
    logic s0_prev_hs;
    always @(negedge tick) begin
        if (reset) begin
            s0_low_pens = 0; s0_fall_col = -1; s0_prev_hs = 1'b1;
        end else begin
            if (pen_w[0] && !hs_w[0]) s0_low_pens++;
            if (s0_prev_hs && !hs_w[0] && s0_fall_col < 0) s0_fall_col = int'(col_w[0]);
            s0_prev_hs = hs_w[0];
        end
    end

    // Small instance: per-frame statistics between consecutive frame_tick pulses.
    int   sm_pens, sm_white, sm_vlow, sm_period, sm_white_last, sm_vlow_last;
    int   sm_ft_n, sm_ft_row, sm_ft_col;
    bit   sm_ft_wide;
    logic sm_prev_ft;
    always @(negedge tick) begin
        if (reset) begin
            sm_pens = 0; sm_white = 0; sm_vlow = 0; sm_period = 0; sm_white_last = 0;
            sm_vlow_last = 0; sm_ft_n = 0; sm_ft_row = -1; sm_ft_col = -1;
            sm_ft_wide = 1'b0; sm_prev_ft = 1'b0;
        end else begin
            if (pen_w[1]) begin
                sm_pens++;
                if (rgb_w[1] == 3'b111) sm_white++;
                if (!vs_w[1]) sm_vlow++;
            end
            if (ft_w[1]) begin
                if (sm_prev_ft) sm_ft_wide = 1'b1;
                sm_period = sm_pens; sm_white_last = sm_white; sm_vlow_last = sm_vlow;
                sm_ft_row = int'(row_w[1]); sm_ft_col = int'(col_w[1]);
                sm_ft_n++;
                sm_pens = 0; sm_white = 0; sm_vlow = 0;
            end
            sm_prev_ft = ft_w[1];
        end
    end

    // Fast instance: line period in ticks and active-high hsync width per line.
    int f_ticks, f_hs_hi, f_line, f_hs_line, f_wraps, f_pen_low, f_prev_col;
    always @(negedge tick) begin
        if (reset) begin
            f_ticks = 0; f_hs_hi = 0; f_line = 0; f_hs_line = 0;
            f_wraps = 0; f_pen_low = 0; f_prev_col = 0;
        end else begin
            if (col_w[2] == 10'd0 && f_prev_col == 799) begin
                f_line = f_ticks; f_hs_line = f_hs_hi; f_ticks = 0; f_hs_hi = 0; f_wraps++;
            end
            f_ticks++;
            if (hs_w[2]) f_hs_hi++;
            if (!pen_w[2]) f_pen_low++;
            f_prev_col = int'(col_w[2]);
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        rgb_in = 3'b111;

        // Reset state
        repeat (3) @(negedge tick);
        check("rst_row", 32'(row_w[0]), 32'd0);
        check("rst_col", 32'(col_w[0]), 32'd0);
        check("rst_rgb", 32'(rgb_w[0]), 32'd0);
        check("rst_hsync", 32'(hs_w[0]), 32'd1);
        check("rst_vsync", 32'(vs_w[0]), 32'd1);
        check("rst_frame_tick", 32'(ft_w[0]), 32'd0);
        check("rst_pixel_en", 32'(pen_w[0]), 32'd0);
        check("rst_fast_hsync", 32'(hs_w[2]), 32'd0);
        #2 reset = 1'b0;

        // First pixel strobes after release
        for (int i = 1; i <= 6; i++) begin
            @(negedge tick);
            check($sformatf("start_pen_%0d", i), 32'(pen_w[0]), 32'(i % 2));
            check($sformatf("start_col_%0d", i), 32'(col_w[0]), 32'(i / 2));
            check($sformatf("start_hsync_%0d", i), 32'(hs_w[0]), 32'd1);
            check($sformatf("start_vsync_%0d", i), 32'(vs_w[0]), 32'd1);
            check($sformatf("fast_pen_%0d", i), 32'(pen_w[2]), 32'd1);
        end

        // One full line on the standard instance
        n = 0;
        while (col_w[0] != 10'd799 && n < 2000) begin @(negedge tick); n++; end
        check("wait_col_799", 32'(n < 2000), 32'd1);
        n = 0;
        while (col_w[0] == 10'd799 && n < 8) begin @(negedge tick); n++; end
        check("line_wrap_col", 32'(col_w[0]), 32'd0);
        check("line_wrap_row", 32'(row_w[0]), 32'd1);
        check("hsync_low_pixels", 32'(s0_low_pens), 32'd96);
        check("hsync_first_low_col", 32'(s0_fall_col), 32'd657);

        // Fast instance line timing
        n = 0;
        while (f_wraps < 2 && n < 2000) begin @(negedge tick); n++; end
        check("fast_wait_lines", 32'(f_wraps >= 2), 32'd1);
        check("fast_line_ticks", 32'(f_line), 32'd800);
        check("fast_hsync_high_ticks", 32'(f_hs_line), 32'd96);
        check("fast_pen_never_low", 32'(f_pen_low), 32'd0);

        // Small instance whole-frame statistics
        n = 0;
        while (sm_ft_n < 3 && n < 3000) begin @(negedge tick); n++; end
        check("small_wait_frames", 32'(sm_ft_n >= 3), 32'd1);
        check("small_frame_period", 32'(sm_period), 32'd165);
        check("small_white_pixels", 32'(sm_white_last), 32'd48);
        check("small_vsync_low_pixels", 32'(sm_vlow_last), 32'd30);
        check("small_frame_tick_wide", 32'(sm_ft_wide), 32'd0);
        check("small_frame_tick_row", 32'(sm_ft_row), 32'd6);
        check("small_frame_tick_col", 32'(sm_ft_col), 32'd0);

        // Random colours, then reset mid-line
        repeat (200) begin
            @(negedge tick);
            #2 rgb_in = 3'($urandom_range(0, 7));
        end
        n = 0;
        while (!(row_w[0] == 10'd1 && col_w[0] == 10'd300) && n < 4000) begin
            @(negedge tick); n++;
        end
        check("wait_mid_line", 32'(n < 4000), 32'd1);
        #2 rgb_in = 3'b101;
        reset = 1'b1;
        @(negedge tick);
        check("mid_rst_row", 32'(row_w[0]), 32'd0);
        check("mid_rst_col", 32'(col_w[0]), 32'd0);
        check("mid_rst_rgb", 32'(rgb_w[0]), 32'd0);
        check("mid_rst_hsync", 32'(hs_w[0]), 32'd1);
        check("mid_rst_vsync", 32'(vs_w[0]), 32'd1);
        check("mid_rst_frame_tick", 32'(ft_w[0]), 32'd0);
        #2 reset = 1'b0;
        repeat (300) begin
            @(negedge tick);
            #2 rgb_in = 3'($urandom_range(0, 7));
        end

        @(negedge tick);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
